vga_write_arbiter: RTL and testbench

- Shares the single plot port of the 160x120 VGA adapter between two pixel requesters (req0: 3D renderer, req1: HUD/overlay) and an internal full-screen clear engine.
- Sits between the main controller's drawing units and the adapter's x/y/colour/plot inputs.
- Presents one registered pixel write per cycle at most.

---
 rtl/vga_write_arbiter_if.sv | 70 +++++++
 rtl/vga_write_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter_if
//
// Bundles every signal between the pixel requesters / clear controller and
// the VGA write arbiter, plus the registered plot port to the adapter.
//
// Signals (direction as seen by the arbiter, i.e. the slave modport):
//   req0_valid/x/y/colour  in   renderer pixel request
//   req0_ready             out  renderer request accepted this cycle
//   req1_valid/x/y/colour  in   overlay pixel request
//   req1_ready             out  overlay request accepted this cycle
//   clear_start            in   one-cycle pulse: begin full-screen clear
//   clear_colour           in   fill colour, sampled when the clear starts
//   busy                   out  high while the clear engine owns the port
//   clear_done             out  one-cycle pulse with the final clear write
//   vga_x/vga_y/vga_colour out  registered pixel to the adapter
//   vga_write              out  registered plot strobe
//
// Parameters:
//   COLOUR_BITS  colour word width
// ---------------------------------------------------------------------------
interface vga_write_arbiter_if #(
  parameter int COLOUR_BITS = 18
);

  logic                   req0_valid;
  logic [7:0]             req0_x;
  logic [6:0]             req0_y;
  logic [COLOUR_BITS-1:0] req0_colour;
  logic                   req0_ready;

  logic                   req1_valid;
  logic [7:0]             req1_x;
  logic [6:0]             req1_y;
  logic [COLOUR_BITS-1:0] req1_colour;
  logic                   req1_ready;

  logic                   clear_start;
  logic [COLOUR_BITS-1:0] clear_colour;
  logic                   busy;
  logic                   clear_done;

  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [COLOUR_BITS-1:0] vga_colour;
  logic                   vga_write;

  // Requesters / controller side.
  modport master (
    output req0_valid, req0_x, req0_y, req0_colour,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_colour,
    input  req1_ready,
    output clear_start, clear_colour,
    input  busy, clear_done,
    input  vga_x, vga_y, vga_colour, vga_write
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_x, req0_y, req0_colour,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_colour,
    output req1_ready,
    input  clear_start, clear_colour,
    output busy, clear_done,
    output vga_x, vga_y, vga_colour, vga_write
  );

endinterface

// File: rtl/vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter
//
// Shares the single plot port of a WIDTH x HEIGHT VGA adapter between two
// pixel requesters (req0: renderer, req1: overlay) and an internal
// full-screen clear engine. At most one registered pixel write is presented
// per cycle; an accepted request appears on the plot port one cycle later.
//
// Arbitration (state IDLE):
//   - a single valid requester is accepted immediately;
//   - when both are valid, the requester not granted last wins
//     (round-robin pointer starts on req1, so req0 wins the first tie);
//   - a ready is never raised without its valid, and never during reset.
//
// Clear engine (state CLEAR):
//   - entered on clear_start in IDLE; clear_colour is captured then;
//   - issues one pixel per cycle in raster order, blocking both requesters;
//   - clear_done pulses together with the last (WIDTH-1, HEIGHT-1) write;
//   - clear_start while clearing is ignored.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset (aborts a clear, no clear_done)
//   bus    vga_write_arbiter_if.slave, see the interface for signal list
//
// Parameters:
//   WIDTH        screen width in pixels  (x range 0..WIDTH-1,  WIDTH  <= 256)
//   HEIGHT       screen height in pixels (y range 0..HEIGHT-1, HEIGHT <= 128)
//   COLOUR_BITS  colour word width; must match the interface instance
//
// Build option:
//   ARB_CLIP_EN  when defined, a granted request with x >= WIDTH or
//                y >= HEIGHT is still handshaken (and consumes the
//                round-robin turn) but produces no write and leaves the
//                output registers untouched. When undefined every accepted
//                request is written unmodified.
// ---------------------------------------------------------------------------
module vga_write_arbiter #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int COLOUR_BITS = 18
) (
  input logic                clock,
  input logic                reset,
  vga_write_arbiter_if.slave bus
);

  // Last valid raster coordinates, sized to the coordinate buses.
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // Clear engine.
  logic [7:0]             r_clr_x;
  logic [6:0]             r_clr_y;
  logic [COLOUR_BITS-1:0] r_clr_colour;

  // Round-robin pointer: 1 means req1 was granted last.
  logic                   r_last_grant;

  // Registered plot port.
  logic                   r_vga_write;
  logic [7:0]             r_vga_x;
  logic [6:0]             r_vga_y;
  logic [COLOUR_BITS-1:0] r_vga_colour;
  logic                   r_clear_done;

  // Decode from the next-state process.
  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_clr_start;
  logic                   w_clr_last;

  // Selected request.
  logic                   w_xfer;
  logic [7:0]             w_req_x;
  logic [6:0]             w_req_y;
  logic [COLOUR_BITS-1:0] w_req_colour;
  logic                   w_req_write;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, grants and clear-engine control
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_clr_start = 1'b0;
    w_clr_last  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Grants are suppressed while reset is held: a handshake in that
        // cycle would be lost when the registers clear.
        if (!reset) begin
          if (bus.req0_valid && bus.req1_valid) begin
            w_grant0 = r_last_grant;
            w_grant1 = !r_last_grant;
          end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
          end
        end
        // A request granted in the same cycle is still written; the clear
        // starts issuing pixels from the next cycle.
        if (bus.clear_start) begin
          w_clr_start = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        w_clr_last = (r_clr_x == X_LAST) && (r_clr_y == Y_LAST);
        if (w_clr_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.busy       = (r_state == ST_CLEAR);

  // -------------------------------------------------------------------------
  // Request select and optional clipping
  // -------------------------------------------------------------------------
  assign w_xfer       = w_grant0 || w_grant1;
  assign w_req_x      = w_grant1 ? bus.req1_x      : bus.req0_x;
  assign w_req_y      = w_grant1 ? bus.req1_y      : bus.req0_y;
  assign w_req_colour = w_grant1 ? bus.req1_colour : bus.req0_colour;

`ifdef ARB_CLIP_EN
  // Off-screen pixels are swallowed: handshake completes, nothing is plotted.
  assign w_req_write = w_xfer && (w_req_x <= X_LAST) && (w_req_y <= Y_LAST);
`else
  assign w_req_write = w_xfer;
`endif

  // -------------------------------------------------------------------------
  // Round-robin pointer: moves on every handshake, plotted or clipped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_last_grant <= w_grant1;
    end
  end

  // -------------------------------------------------------------------------
  // Clear raster counters. They are zeroed on start and wrap back to zero
  // after the final pixel, so they never hold an off-screen coordinate.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_x <= '0;
      r_clr_y <= '0;
    end else if (w_clr_start) begin
      r_clr_x <= '0;
      r_clr_y <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_x == X_LAST) begin
        r_clr_x <= '0;
        r_clr_y <= w_clr_last ? 7'd0 : r_clr_y + 7'd1;
      end else begin
        r_clr_x <= r_clr_x + 8'd1;
      end
    end
  end

  // NOTE: the fill colour is deliberately left out of reset; it is only
  // read in CLEAR, and CLEAR can only be entered through the cycle that
  // loads it.
  always_ff @(posedge clock) begin
    if (w_clr_start) begin
      r_clr_colour <= bus.clear_colour;
    end
  end

  // -------------------------------------------------------------------------
  // Registered plot port. Coordinates and colour hold when nothing is
  // written; the strobe and clear_done are single-cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vga_write  <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_vga_write  <= 1'b0;
      r_clear_done <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_vga_write  <= 1'b1;
        r_vga_x      <= r_clr_x;
        r_vga_y      <= r_clr_y;
        r_vga_colour <= r_clr_colour;
        r_clear_done <= w_clr_last;
      end else if (w_req_write) begin
        r_vga_write  <= 1'b1;
        r_vga_x      <= w_req_x;
        r_vga_y      <= w_req_y;
        r_vga_colour <= w_req_colour;
      end
    end
  end

  assign bus.vga_write  = r_vga_write;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.clear_done = r_clear_done;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_write_arbiter
//
// Randomised and directed stimulus for vga_write_arbiter. A reference model
// (pixel index arithmetic, a grant-history bit, expected plot registers)
// advances once per cycle on the falling edge and every output is compared
// against it. Directed sections pin the model with hand-computed literals.
// Compile with +define+ARB_CLIP_EN to exercise the clipping build.
// ---------------------------------------------------------------------------
module tb_vga_write_arbiter;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int CB   = 18;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_write_arbiter_if #(.COLOUR_BITS(CB)) bus ();

  vga_write_arbiter #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COLOUR_BITS(CB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  bit            live    = 1'b0;
  int            m_idx   = -1;    // next clear pixel index, -1 when not clearing
  bit            m_last1 = 1'b1;  // req1 granted last
  logic          m_write = 1'b0;
  logic          m_done  = 1'b0;
  logic [7:0]    m_x     = '0;
  logic [6:0]    m_y     = '0;
  logic [CB-1:0] m_col   = '0;
  logic [CB-1:0] m_clr_col = '0;

  bit            e0, e1, e_busy, in_rng;

  always @(negedge clk) begin
    e_busy = (m_idx >= 0);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !e_busy) begin
      if (bus.req0_valid && bus.req1_valid) begin
        e0 = m_last1;
        e1 = !m_last1;
      end else begin
        e0 = bus.req0_valid;
        e1 = bus.req1_valid;
      end
    end

    if (live) begin
      check("req0_ready", 64'(bus.req0_ready), 64'(e0));
      check("req1_ready", 64'(bus.req1_ready), 64'(e1));
      check("busy",       64'(bus.busy),       64'(e_busy));
      check("clear_done", 64'(bus.clear_done), 64'(m_done));
      check("vga_write",  64'(bus.vga_write),  64'(m_write));
      check("vga_xyc",    64'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                          64'({m_x, m_y, m_col}));
    end

    // Advance to the values expected after the coming rising edge.
    if (rst) begin
      m_idx   = -1;
      m_last1 = 1'b1;
      m_write = 1'b0;
      m_done  = 1'b0;
      m_x     = '0;
      m_y     = '0;
      m_col   = '0;
    end else begin
      m_write = 1'b0;
      m_done  = 1'b0;
      if (e_busy) begin
        m_write = 1'b1;
        m_x     = 8'(m_idx % W);
        m_y     = 7'(m_idx / W);
        m_col   = m_clr_col;
        m_done  = (m_idx == NPIX - 1);
        m_idx   = m_done ? -1 : m_idx + 1;
      end else begin
        if (e0 || e1) begin
          m_last1 = e1;
`ifdef ARB_CLIP_EN
          in_rng = e1 ? (int'(bus.req1_x) < W && int'(bus.req1_y) < H)
                      : (int'(bus.req0_x) < W && int'(bus.req0_y) < H);
`else
          in_rng = 1'b1;
`endif
          if (in_rng) begin
            m_write = 1'b1;
            m_x     = e1 ? bus.req1_x      : bus.req0_x;
            m_y     = e1 ? bus.req1_y      : bus.req0_y;
            m_col   = e1 ? bus.req1_colour : bus.req0_colour;
          end
        end
        if (bus.clear_start) begin
          m_clr_col = bus.clear_colour;
          m_idx     = 0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.clear_start = 1'b0;
  endtask

  task automatic rand_requests();
    bus.req0_valid  = 1'($urandom_range(0, 1));
    bus.req0_x      = 8'($urandom);
    bus.req0_y      = 7'($urandom);
    bus.req0_colour = CB'($urandom);
    bus.req1_valid  = 1'($urandom_range(0, 1));
    bus.req1_x      = 8'($urandom);
    bus.req1_y      = 7'($urandom);
    bus.req1_colour = CB'($urandom);
  endtask

  // Runs one clear from IDLE. A req0 pixel (7,9) is presented in the start
  // cycle and must still be plotted. Optionally re-pulses clear_start once
  // write number pulse_at has been seen.
  task automatic run_clear(input logic [CB-1:0] col, input int pulse_at, input bit rand_req,
                           output int writes, output int dones,
                           output logic [7:0] lx, output logic [6:0] ly, output logic [CB-1:0] lcol);
    writes = 0;
    dones  = 0;
    lx     = '0;
    ly     = '0;
    lcol   = '0;
    cyc();
    bus.clear_start  = 1'b1;
    bus.clear_colour = col;
    bus.req0_valid   = 1'b1;
    bus.req0_x       = 8'd7;
    bus.req0_y       = 7'd9;
    bus.req0_colour  = 18'h00155;
    bus.req1_valid   = 1'b0;
    @(negedge clk);
    check("start_req0_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("start_busy",    64'(bus.busy),      64'd1);
    check("start_write",   64'(bus.vga_write), 64'd1);
    check("start_xy",      64'({bus.vga_x, bus.vga_y}), 64'({8'd7, 7'd9}));
    for (int k = 0; k < NPIX + 50 && dones == 0; k++) begin
      cyc();
      if (rand_req) rand_requests();
      bus.clear_start  = (pulse_at >= 0 && writes == pulse_at);
      bus.clear_colour = CB'($urandom);
      @(negedge clk);
      if (bus.vga_write) begin
        writes++;
        if (writes == 1) begin
          check("clear_first_xy", 64'({bus.vga_x, bus.vga_y}), 64'd0);
        end
      end
      if (bus.busy) begin
        check("clear_no_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      end
      if (bus.clear_done) begin
        dones++;
        lx   = bus.vga_x;
        ly   = bus.vga_y;
        lcol = bus.vga_colour;
      end
    end
    cyc();
    idle_inputs();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.clear_done) dones++;
      cyc();
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  int            n_wr, n_done;
  logic [7:0]    lx;
  logic [6:0]    ly;
  logic [CB-1:0] lcol;

  initial begin
    idle_inputs();
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_colour = '0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_colour = '0;
    bus.clear_colour = '0;

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
    live = 1'b1;
    @(negedge clk);
    check("reset_write", 64'(bus.vga_write), 64'd0);
    check("reset_xyc",   64'({bus.vga_x, bus.vga_y, bus.vga_colour}), 64'd0);
    check("reset_busy",  64'(bus.busy), 64'd0);
    check("reset_done",  64'(bus.clear_done), 64'd0);

    // Tie: req0 first after reset, then strict alternation
    cyc();
    bus.req0_valid = 1'b1; bus.req0_x = 8'd1; bus.req0_y = 7'd2; bus.req0_colour = 18'h00111;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd3; bus.req1_y = 7'd4; bus.req1_colour = 18'h00222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie_req0_ready", 64'(bus.req0_ready), 64'((i % 2) == 0));
      check("tie_req1_ready", 64'(bus.req1_ready), 64'((i % 2) == 1));
      if (i > 0) begin
        check("tie_vga_x", 64'(bus.vga_x), ((i % 2) == 1) ? 64'd1 : 64'd3);
      end
      cyc();
    end

    // Single renderer pixel, one-cycle latency
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_x = 8'd10; bus.req0_y = 7'd20; bus.req0_colour = 18'h3FFFF;
    @(negedge clk);
    check("single_req0_ready", 64'(bus.req0_ready), 64'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("single_write", 64'(bus.vga_write), 64'd1);
    check("single_xyc",   64'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                          64'({8'd10, 7'd20, 18'h3FFFF}));

    // Random arbitration traffic
    for (int i = 0; i < 1500; i++) begin
      cyc();
      rand_requests();
    end
    cyc();
    idle_inputs();

    // Full clear with random requesters knocking
    run_clear(18'h00FC0, -1, 1'b1, n_wr, n_done, lx, ly, lcol);
    check("clear_writes",  64'(n_wr),   64'(NPIX));
    check("clear_dones",   64'(n_done), 64'd1);
    check("clear_last_xy", 64'({lx, ly}), 64'({8'd159, 7'd119}));
    check("clear_colour",  64'(lcol), 64'(18'h00FC0));

    // clear_start re-pulsed mid-clear is ignored
    run_clear(18'h2A5A5, 5000, 1'b0, n_wr, n_done, lx, ly, lcol);
    check("restart_writes", 64'(n_wr),   64'(NPIX));
    check("restart_dones",  64'(n_done), 64'd1);
    check("restart_last",   64'({lx, ly, lcol}), 64'({8'd159, 7'd119, 18'h2A5A5}));

    // Reset aborts a clear at write 100
    cyc();
    bus.clear_start  = 1'b1;
    bus.clear_colour = 18'h00003;
    cyc();
    idle_inputs();
    n_wr = 0;
    for (int k = 0; k < 200 && n_wr < 100; k++) begin
      cyc();
      @(negedge clk);
      if (bus.vga_write) n_wr++;
    end
    check("abort_reached_100", 64'(n_wr), 64'd100);
    cyc();
    rst = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd50; bus.req1_y = 7'd60; bus.req1_colour = 18'h01234;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",       64'(bus.busy),       64'd0);
    check("abort_write",      64'(bus.vga_write),  64'd0);
    check("abort_req1_ready", 64'(bus.req1_ready), 64'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("abort_req1_xy", 64'({bus.vga_write, bus.vga_x, bus.vga_y}), 64'({1'b1, 8'd50, 7'd60}));
    n_done = 0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      @(negedge clk);
      if (bus.clear_done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    // Off-screen overlay pixel (160,5)
    cyc();
    bus.req1_valid = 1'b1; bus.req1_x = 8'd160; bus.req1_y = 7'd5; bus.req1_colour = 18'h00ABC;
    @(negedge clk);
    check("clip_req1_ready", 64'(bus.req1_ready), 64'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
`ifdef ARB_CLIP_EN
    check("clip_write", 64'(bus.vga_write), 64'd0);
`else
    check("clip_write", 64'(bus.vga_write), 64'd1);
    check("clip_x",     64'(bus.vga_x),     64'd160);
`endif

    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
